// File: rtl/instr_encoder_loader.sv
// Program-load path for the single-cycle core: encodes symbolic instruction
// requests into 32-bit MIPS words and writes them sequentially into
// instruction memory starting at BASE_ADDR.
//
// Handshake: a request is accepted on a rising edge where InValid && InReady.
// InReady is high only while loading and waiting for a request. Requests
// presented while InReady is low are ignored and not queued.
module instr_encoder_loader #(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Finish,
  input  logic              InValid,
  output logic              InReady,
  input  logic [3:0]        InOp,
  input  logic [4:0]        InRs,
  input  logic [4:0]        InRt,
  input  logic [4:0]        InRd,
  input  logic [15:0]       InImm,
  input  logic [25:0]       InTarget,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic [ADDR_W:0]   Count,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_we_q;
  logic              error_q;
  logic              finish_lat_q;
  logic              enc_legal;
  logic [31:0]       enc_word;

  assign count_inc = count_q + 1'b1;

  // Encode the current request; opcodes 11..15 have no encoding.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (InOp)
      4'd0:    enc_word = {6'b000000, InRs, InRt, InRd, 5'b00000, 6'b100000};
      4'd1:    enc_word = {6'b000000, InRs, InRt, InRd, 5'b00000, 6'b100010};
      4'd2:    enc_word = {6'b000000, InRs, InRt, InRd, 5'b00000, 6'b100100};
      4'd3:    enc_word = {6'b000000, InRs, InRt, InRd, 5'b00000, 6'b100101};
      4'd4:    enc_word = {6'b000000, InRs, InRt, InRd, 5'b00000, 6'b101010};
      4'd5:    enc_word = {6'b100011, InRs, InRt, InImm};
      4'd6:    enc_word = {6'b101011, InRs, InRt, InImm};
      4'd7:    enc_word = {6'b000100, InRs, InRt, InImm};
      4'd8:    enc_word = {6'b001000, InRs, InRt, InImm};
      4'd9:    enc_word = {6'b001100, InRs, InRt, InImm};
      4'd10:   enc_word = {6'b000010, InTarget};
      default: enc_legal = 1'b0;
    endcase
  end

  // Load FSM: accept a request, spend exactly one cycle writing it, advance.
  // A Start in any state begins a fresh load; in WRITE the strobe cycle in
  // flight still completes before the restart takes effect.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= BASE;
      count_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      error_q      <= 1'b0;
      finish_lat_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_q      <= S_LOAD;
            count_q      <= '0;
            addr_q       <= BASE;
            error_q      <= 1'b0;
            finish_lat_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (Start) begin
            count_q      <= '0;
            addr_q       <= BASE;
            error_q      <= 1'b0;
            finish_lat_q <= 1'b0;
          end else if (InValid) begin
            if (enc_legal) begin
              mem_addr_q   <= addr_q;
              mem_wdata_q  <= enc_word;
              mem_we_q     <= 1'b1;
              finish_lat_q <= Finish;
              state_q      <= S_WRITE;
            end else begin
              // Illegal request is consumed without a write.
              error_q <= 1'b1;
              if (Finish) state_q <= S_DONE;
            end
          end else if (Finish) begin
            state_q <= S_DONE;
          end
        end
        S_WRITE: begin
          count_q      <= count_inc;
          addr_q       <= addr_q + 1'b1;
          finish_lat_q <= 1'b0;
          if (Start) begin
            state_q <= S_LOAD;
            count_q <= '0;
            addr_q  <= BASE;
            error_q <= 1'b0;
          end else if (count_inc == DEPTH_C || finish_lat_q || Finish) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign InReady  = (state_q == S_LOAD);
  assign Busy     = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign Done     = (state_q == S_DONE);
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign Count    = count_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed vectors plus randomized loads
// checked against a table-driven encoding model and a write scoreboard.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int EW     = ADDR_W + 32;

  logic              Clk;
  logic              Rst_n;
  logic              Start;
  logic              Finish;
  logic              InValid;
  logic              InReady;
  logic [3:0]        InOp;
  logic [4:0]        InRs;
  logic [4:0]        InRt;
  logic [4:0]        InRd;
  logic [15:0]       InImm;
  logic [25:0]       InTarget;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWData;
  logic [ADDR_W:0]   Count;
  logic              Busy;
  logic              Done;
  logic              Error;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  int   exp_addr;
  int   exp_count;
  logic exp_error;

  logic [5:0] funct_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  logic [5:0] opc_tab   [5] = '{6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c};

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Finish(Finish),
    .InValid(InValid), .InReady(InReady), .InOp(InOp), .InRs(InRs),
    .InRt(InRt), .InRd(InRd), .InImm(InImm), .InTarget(InTarget),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .Count(Count),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  // Clock and global time limit
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  // Reference encoder built from the format tables
  function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    int o;
    o = int'(op);
    if (o < 5)       return {6'd0, rs, rt, rd, 5'd0, funct_tab[o]};
    else if (o < 10) return {opc_tab[o-5], rs, rt, imm};
    else if (o == 10) return {6'b000010, tgt};
    else             return 32'd0;
  endfunction

  // Scoreboard: every write strobe cycle must match the oldest expected write
  always @(negedge Clk) begin
    if (Rst_n && MemWe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%0d data=%h", MemAddr, MemWData);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({MemAddr, MemWData} !== e) begin
          errors++;
          $display("FAIL write_data got addr=%0d data=%h want addr=%0d data=%h",
                   MemAddr, MemWData, e[EW-1:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    exp_count = 0;
    exp_addr  = 0;
    exp_error = 1'b0;
    checks++;
    if ({InReady, Busy, Done, Error, Count} !== {1'b1, 1'b1, 1'b0, 1'b0, (ADDR_W+1)'(0)}) begin
      errors++;
      $display("FAIL start_state got rdy=%b busy=%b done=%b err=%b cnt=%0d want 1 1 0 0 0",
               InReady, Busy, Done, Error, Count);
    end
  endtask

  task automatic do_finish();
    Finish = 1'b1;
    tick();
    Finish = 1'b0;
    checks++;
    if ({Done, Busy, InReady} !== 3'b100) begin
      errors++;
      $display("FAIL finish_state got done=%b busy=%b rdy=%b want 1 0 0", Done, Busy, InReady);
    end
  endtask

  // Drive one request once InReady is seen, then check write strobe and counters
  task automatic send_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
      input logic fin, input logic [31:0] word);
    int   waited;
    logic legal;
    logic exp_done;
    waited = 0;
    legal  = (op <= 4'd10);
    while (InReady !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got rdy=%b want 1", InReady);
      return;
    end
    InOp = op; InRs = rs; InRt = rt; InRd = rd; InImm = imm; InTarget = tgt;
    InValid = 1'b1;
    Finish  = fin;
    if (legal) exp_q.push_back({ADDR_W'(exp_addr), word});
    tick();
    InValid = 1'b0;
    Finish  = 1'b0;
    checks++;
    if (MemWe !== legal) begin
      errors++;
      $display("FAIL mem_we op=%0d got %b want %b", op, MemWe, legal);
    end
    if (legal) begin
      tick();
      exp_count++;
      exp_addr = (exp_addr + 1) % (1 << ADDR_W);
    end else begin
      exp_error = 1'b1;
    end
    exp_done = fin || (legal && exp_count == DEPTH);
    checks++;
    if (Count !== (ADDR_W+1)'(exp_count)) begin
      errors++;
      $display("FAIL count got %0d want %0d", Count, exp_count);
    end
    checks++;
    if (Error !== exp_error) begin
      errors++;
      $display("FAIL error_flag got %b want %b", Error, exp_error);
    end
    checks++;
    if (Done !== exp_done) begin
      errors++;
      $display("FAIL done got %b want %b", Done, exp_done);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Start = 1'b0; Finish = 1'b0; InValid = 1'b0;
    InOp = '0; InRs = '0; InRt = '0; InRd = '0; InImm = '0; InTarget = '0;
    repeat (3) tick();
    checks++;
    if ({MemWe, MemAddr, MemWData, Count, Busy, Done, Error, InReady} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%0d data=%h cnt=%0d busy=%b done=%b err=%b rdy=%b want all 0",
               MemWe, MemAddr, MemWData, Count, Busy, Done, Error, InReady);
    end
    Rst_n = 1'b1;
    tick();
    // Reset asserted in the middle of a write strobe
    do_start();
    InOp = 4'd0; InRs = 5'd1; InRt = 5'd2; InRd = 5'd3;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    checks++;
    if (MemWe !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_we got %b want 1", MemWe);
    end
    Rst_n = 1'b0;
    #1;
    checks++;
    if (MemWe !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_we got %b want 0", MemWe);
    end
    tick();
    Rst_n = 1'b1;
    tick();
    checks++;
    if ({Count, Done, Busy, InReady} !== '0) begin
      errors++;
      $display("FAIL reset_release got cnt=%0d done=%b busy=%b rdy=%b want 0 0 0 0",
               Count, Done, Busy, InReady);
    end
  endtask

  task automatic test_add();
    do_start();
    send_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h00221820);
    do_finish();
  endtask

  task automatic test_formats();
    do_start();
    send_req(4'd5, 5'd29, 5'd8, 5'd0, 16'hFFFC, 26'h0, 1'b0, 32'h8FA8FFFC);
    send_req(4'd9, 5'd4, 5'd5, 5'd0, 16'h00FF, 26'h0, 1'b0, 32'h308500FF);
    send_req(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b0, 32'h08000040);
    do_finish();
  endtask

  task automatic test_illegal();
    do_start();
    send_req(4'd13, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0, 1'b0, 32'h0);
    send_req(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 32'h00853020);
    do_finish();
  endtask

  task automatic test_back_to_back();
    logic [4:0] rs, rt, rd;
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      send_req(4'd1, rs, rt, rd, 16'h0, 26'h0, 1'b0, ref_encode(4'd1, rs, rt, rd, 16'h0, 26'h0));
    end
    checks++;
    if (InReady !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b want 0", InReady);
    end
    // Extra request after auto-finish must be ignored
    InOp = 4'd0; InValid = 1'b1;
    repeat (3) tick();
    InValid = 1'b0;
    checks++;
    if (Count !== (ADDR_W+1)'(DEPTH) || Done !== 1'b1) begin
      errors++;
      $display("FAIL full_ignore got cnt=%0d done=%b want %0d 1", Count, Done, DEPTH);
    end
  endtask

  task automatic test_finish_with_accept();
    do_start();
    send_req(4'd7, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0, 1'b1, 32'h10220010);
  endtask

  task automatic test_restart();
    do_start();
    send_req(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 32'h00210820);
    send_req(4'd0, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 1'b0, 32'h00421020);
    // Start while waiting for a request
    do_start();
    // Start while a write is in flight: that write still lands at address 0
    InOp = 4'd3; InRs = 5'd3; InRt = 5'd4; InRd = 5'd5; InValid = 1'b1;
    exp_q.push_back({ADDR_W'(0), 32'h00642825});
    tick();
    InValid = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (Count !== '0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL restart_write got cnt=%0d rdy=%b want 0 1", Count, InReady);
    end
    exp_count = 0;
    exp_addr  = 0;
    send_req(4'd4, 5'd6, 5'd7, 5'd8, 16'h0, 26'h0, 1'b0, 32'h00C7402A);
    do_finish();
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    int n;
    logic fin;
    for (int l = 0; l < 12; l++) begin
      do_start();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        op  = 4'($urandom_range(0, 15));
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        tgt = 26'($urandom);
        fin = (k == n - 1);
        repeat ($urandom_range(0, 2)) tick();
        send_req(op, rs, rt, rd, imm, tgt, fin, ref_encode(op, rs, rt, rd, imm, tgt));
        if (Done === 1'b1) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_formats();
    test_illegal();
    test_back_to_back();
    test_finish_with_accept();
    test_restart();
    test_random();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
